pa_fadd_norm_shift: RTL and testbench



---
 rtl/pa_fadd_norm_shift_pkg.sv | 9 +
 rtl/pa_fadd_norm_shift_if.sv | 23 ++
 rtl/pa_fadd_norm_lzc.sv | 34 +++
 rtl/pa_fadd_norm_shift.sv | 110 +++++++++++
 tb/tb_pa_fadd_norm_shift.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pa_fadd_norm_shift_pkg.sv
// pa_fadd_norm_shift_pkg: shared FPU adder defaults and shift-count width helper
package pa_fadd_norm_shift_pkg;
  localparam int DATA_W_DEF = 28;
  localparam int EXP_W_DEF  = 10;
  localparam int TAG_W_DEF  = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pa_fadd_norm_shift_if.sv
// pa_fadd_norm_shift_if: in/out valid-ready beat channels plus flush; master drives beats, slave normalises
interface pa_fadd_norm_shift_if
  import pa_fadd_norm_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  localparam int CNT_W = cnt_w(DATA_W)
);
  logic              in_vld, in_rdy, flush, out_vld, out_rdy, out_zero;
  logic [DATA_W-1:0] in_data, out_data;
  logic [EXP_W-1:0]  in_exp, out_exp;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [CNT_W-1:0]  out_shift;
  modport master (
    output in_vld, in_data, in_exp, in_tag, flush, out_rdy,
    input  in_rdy, out_vld, out_data, out_exp, out_shift, out_zero, out_tag
  );
  modport slave (
    input  in_vld, in_data, in_exp, in_tag, flush, out_rdy,
    output in_rdy, out_vld, out_data, out_exp, out_shift, out_zero, out_tag
  );
endinterface

// File: rtl/pa_fadd_norm_lzc.sv
// pa_fadd_norm_lzc: combinational leading-zero counter (data in; lzc, all-zero flag out) built as a 2-bit priority-encoder tree
module pa_fadd_norm_lzc
  import pa_fadd_norm_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  localparam int CNT_W = cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  lzc,
  output logic              zero
);
  localparam int K = $clog2(DATA_W);
  localparam int P = 1 << K;
  logic [P-1:0]   x;
  logic [2*P-2:0] v;
  logic [K-1:0]   c [2*P-1];
  always_comb begin
    x = P'(data) << (P - DATA_W);
    v = '0;
    for (int j = 0; j < P; j++) begin
      v[P-1+j] = x[P-1-j];
      c[P-1+j] = '0;
    end
    for (int d = K - 1; d >= 0; d--)
      for (int j = 0; j < (1 << d); j++) begin
        int n;
        n = (1 << d) - 1 + j;
        v[n] = v[2*n+1] | v[2*n+2];
        c[n] = v[2*n+1] ? c[2*n+1] : (c[2*n+2] | K'(P >> (d + 1)));
      end
    zero = ~|data;
    lzc = zero ? CNT_W'(DATA_W) : CNT_W'(c[0]);
  end
endmodule

// File: rtl/pa_fadd_norm_shift.sv
// pa_fadd_norm_shift: clamped LZC normalise shift + exponent adjust, 1/2-stage valid-ready pipe (forever_cpuclk, cpurst, bus slave)
module pa_fadd_norm_shift
  import pa_fadd_norm_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int STAGES = 2,
  localparam int CNT_W = cnt_w(DATA_W)
) (
  input logic                 forever_cpuclk,
  input logic                 cpurst,
  pa_fadd_norm_shift_if.slave bus
);
  localparam int MW = (EXP_W > CNT_W ? EXP_W : CNT_W) + 1;
  logic [CNT_W-1:0]  lzc, in_shift, s_shift, out_shift_q, out_shift_d;
  logic              in_zero, s_vld, s_zero, b_free, load_b;
  logic              out_vld_q, out_vld_d, out_zero_q, out_zero_d;
  logic [MW-1:0]     lim;
  logic [DATA_W-1:0] s_data, sh_data, out_data_q, out_data_d;
  logic [EXP_W-1:0]  s_exp, out_exp_q, out_exp_d;
  logic [TAG_W-1:0]  s_tag, out_tag_q, out_tag_d;
  if (STAGES != 1 && STAGES != 2) begin : g_bad
    $error("pa_fadd_norm_shift: STAGES must be 1 or 2");
  end
  pa_fadd_norm_lzc #(.DATA_W(DATA_W)) u_lzc (.data(bus.in_data), .lzc(lzc), .zero(in_zero));
  always_comb begin
    lim = MW'(bus.in_exp) - MW'(1);
    in_shift = (in_zero || bus.in_exp == '0) ? '0 : (lim < MW'(lzc) ? CNT_W'(lim) : lzc);
  end
  always_comb b_free = !out_vld_q || bus.out_rdy;
  if (STAGES == 1) begin : g_one
    always_comb begin
      bus.in_rdy = b_free;
      s_vld = bus.in_vld;
      s_data = bus.in_data;
      s_exp = bus.in_exp;
      s_tag = bus.in_tag;
      s_shift = in_shift;
      s_zero = in_zero;
    end
  end else begin : g_two
    logic              a_vld_q, a_vld_d, a_zero_q, a_zero_d, a_free, load_a;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic [EXP_W-1:0]  a_exp_q, a_exp_d;
    logic [TAG_W-1:0]  a_tag_q, a_tag_d;
    logic [CNT_W-1:0]  a_shift_q, a_shift_d;
    always_comb begin
      a_free = !a_vld_q || b_free;
      load_a = bus.in_vld && a_free && !bus.flush;
      a_vld_d = bus.flush ? 1'b0 : load_a ? 1'b1 : b_free ? 1'b0 : a_vld_q;
      a_data_d = load_a ? bus.in_data : a_data_q;
      a_exp_d = load_a ? bus.in_exp : a_exp_q;
      a_tag_d = load_a ? bus.in_tag : a_tag_q;
      a_shift_d = load_a ? in_shift : a_shift_q;
      a_zero_d = load_a ? in_zero : a_zero_q;
      bus.in_rdy = a_free;
      s_vld = a_vld_q;
      s_data = a_data_q;
      s_exp = a_exp_q;
      s_tag = a_tag_q;
      s_shift = a_shift_q;
      s_zero = a_zero_q;
    end
    always_ff @(posedge forever_cpuclk) a_vld_q <= cpurst ? 1'b0 : a_vld_d;
    always_ff @(posedge forever_cpuclk) begin
      a_data_q <= a_data_d;
      a_exp_q <= a_exp_d;
      a_tag_q <= a_tag_d;
      a_shift_q <= a_shift_d;
      a_zero_q <= a_zero_d;
    end
  end
  always_comb begin
    load_b = s_vld && b_free && !bus.flush;
    sh_data = s_data;
    for (int i = 0; i < CNT_W; i++) sh_data = s_shift[i] ? sh_data << (1 << i) : sh_data;
    out_vld_d = bus.flush ? 1'b0 : load_b ? 1'b1 : b_free ? 1'b0 : out_vld_q;
    out_data_d = load_b ? sh_data : out_data_q;
    out_exp_d = load_b ? (s_zero ? '0 : s_exp - EXP_W'(s_shift)) : out_exp_q;
    out_shift_d = load_b ? s_shift : out_shift_q;
    out_zero_d = load_b ? s_zero : out_zero_q;
    out_tag_d = load_b ? s_tag : out_tag_q;
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      out_vld_q <= 1'b0;
      out_data_q <= '0;
      out_exp_q <= '0;
      out_shift_q <= '0;
      out_zero_q <= 1'b0;
      out_tag_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_data_q <= out_data_d;
      out_exp_q <= out_exp_d;
      out_shift_q <= out_shift_d;
      out_zero_q <= out_zero_d;
      out_tag_q <= out_tag_d;
    end
  end
  always_comb begin
    bus.out_vld = out_vld_q;
    bus.out_data = out_data_q;
    bus.out_exp = out_exp_q;
    bus.out_shift = out_shift_q;
    bus.out_zero = out_zero_q;
    bus.out_tag = out_tag_q;
  end
endmodule

// File: tb/tb_pa_fadd_norm_shift.sv
// tb_pa_fadd_norm_shift: scoreboard bench driving a 2-stage and a 1-stage normaliser against a reference model
module tb_pa_fadd_norm_shift;
  import pa_fadd_norm_shift_pkg::*;
  localparam int DW = 28, EW = 10, TW = 4, CW = cnt_w(DW);
  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] exp;
    logic [CW-1:0] shift;
    logic          zero;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;
  logic clk = 0, rst = 1, vld = 0, flush = 0, out_rdy = 0, sel = 0, lat = 0, done = 0, saw = 0;
  logic [DW-1:0] data = '0;
  logic [EW-1:0] expn = '0;
  logic [TW-1:0] tag = '0;
  logic rdy;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t q0[$], q1[$];
  exp_t cap_e, mon_e;
  bit pv[2], pr[2], p_rst = 1, p_flush = 0;
  logic [63:0] pw[2];
  logic [63:0] mw;
  logic mv, qe;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pa_fadd_norm_shift_if #(.DATA_W(DW), .EXP_W(EW), .TAG_W(TW)) b0 ();
  pa_fadd_norm_shift_if #(.DATA_W(DW), .EXP_W(EW), .TAG_W(TW)) b1 ();
  pa_fadd_norm_shift #(.DATA_W(DW), .EXP_W(EW), .TAG_W(TW), .STAGES(2)) u2 (
    .forever_cpuclk(clk), .cpurst(rst), .bus(b0.slave));
  pa_fadd_norm_shift #(.DATA_W(DW), .EXP_W(EW), .TAG_W(TW), .STAGES(1)) u1 (
    .forever_cpuclk(clk), .cpurst(rst), .bus(b1.slave));
  assign b0.in_vld = vld & ~sel;
  assign b1.in_vld = vld & sel;
  assign b0.in_data = data;
  assign b1.in_data = data;
  assign b0.in_exp = expn;
  assign b1.in_exp = expn;
  assign b0.in_tag = tag;
  assign b1.in_tag = tag;
  assign b0.flush = flush;
  assign b1.flush = flush;
  assign b0.out_rdy = out_rdy;
  assign b1.out_rdy = out_rdy;
  assign rdy = sel ? b1.in_rdy : b0.in_rdy;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction
  function automatic exp_t model(logic [DW-1:0] d, logic [EW-1:0] e, logic [TW-1:0] t);
    exp_t r;
    int lz = 0, sh;
    r.tag = t;
    r.cyc = -1;
    if (d == 0) begin
      r.data = '0; r.exp = '0; r.shift = '0; r.zero = 1'b1;
      return r;
    end
    while (!d[DW-1-lz]) lz++;
    sh = (e == 0) ? 0 : (lz < int'(e) - 1 ? lz : int'(e) - 1);
    r.data = d << sh;
    r.exp = e - EW'(sh);
    r.shift = CW'(sh);
    r.zero = 1'b0;
    return r;
  endfunction
  always @(negedge clk) begin
    if (vld && rdy && !flush && !rst) begin
      cap_e = model(data, expn, tag);
      cap_e.cyc = lat ? cyc + (sel ? 1 : 2) : -1;
      if (sel) q1.push_back(cap_e); else q0.push_back(cap_e);
    end
    if (vld && !rdy) saw = 1;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mv = k ? b1.out_vld : b0.out_vld;
      mw = k ? 64'({b1.out_data, b1.out_exp, b1.out_shift, b1.out_zero, b1.out_tag})
             : 64'({b0.out_data, b0.out_exp, b0.out_shift, b0.out_zero, b0.out_tag});
      if (pv[k] && !pr[k] && !p_rst && !p_flush) begin
        chk(k ? "u1 stall_vld" : "u2 stall_vld", 64'(mv), 64'(1));
        chk(k ? "u1 stall_hold" : "u2 stall_hold", mw, pw[k]);
      end
      if (mv && out_rdy) begin
        qe = k ? (q1.size() == 0) : (q0.size() == 0);
        if (qe) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: got output %0h expected none (cycle %0d)", k ? "u1 unexpected" : "u2 unexpected", mw, cyc);
        end else begin
          mon_e = k ? q1.pop_front() : q0.pop_front();
          chk(k ? "u1 result" : "u2 result", mw,
              64'({mon_e.data, mon_e.exp, mon_e.shift, mon_e.zero, mon_e.tag}));
          if (mon_e.cyc >= 0) chk(k ? "u1 latency" : "u2 latency", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      pv[k] = mv;
      pr[k] = out_rdy;
      pw[k] = mw;
    end
    p_rst = rst;
    p_flush = flush;
  end
  task automatic send(input logic [DW-1:0] d, input logic [EW-1:0] e, input logic [TW-1:0] t);
    int n = 0;
    logic acc;
    vld = 1; data = d; expn = e; tag = t;
    do begin
      @(negedge clk);
      acc = rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    vld = 0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_rdy 0 expected 1 within 100 cycles (sel %0d)", sel);
    end
  endtask
  task automatic send_rand();
    logic [DW-1:0] r;
    int lz;
    lz = $urandom_range(0, DW);
    r = DW'($urandom) | {1'b1, {(DW-1){1'b0}}};
    r = (lz == DW) ? '0 : r >> lz;
    send(r, $urandom_range(0, 3) == 0 ? EW'($urandom) : EW'($urandom_range(0, 40)), TW'($urandom));
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(q0.size() + q1.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_state();
    chk("rst u2 in_rdy", 64'(b0.in_rdy), 64'(1));
    chk("rst u1 in_rdy", 64'(b1.in_rdy), 64'(1));
    chk("rst u2 outputs", 64'({b0.out_vld, b0.out_data, b0.out_exp, b0.out_shift, b0.out_zero, b0.out_tag}), 64'(0));
    chk("rst u1 outputs", 64'({b1.out_vld, b1.out_data, b1.out_exp, b1.out_shift, b1.out_zero, b1.out_tag}), 64'(0));
  endtask
  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = 1;
      out_rdy = 1;
      t0 = cyc;
      send(28'h0000001, 10'd100, 4'd1);
      send(28'h0000001, 10'd5, 4'd2);
      send(28'h0000000, 10'd50, 4'd3);
      send(28'h0400000, 10'd0, 4'd4);
      repeat (8) send_rand();
      chk(s ? "u1 throughput" : "u2 throughput", 64'(cyc - t0), 64'(12));
      drain();
      lat = 0;
      saw = 0;
      fork
        for (int i = 0; i < 6; i++) send_rand();
        begin
          repeat (2) @(posedge clk);
          #1 out_rdy = 0;
          repeat (4) @(posedge clk);
          #1 out_rdy = 1;
        end
      join
      drain();
      chk(s ? "u1 in_rdy_drop" : "u2 in_rdy_drop", 64'(saw), 64'(1));
      done = 0;
      fork
        begin
          for (int i = 0; i < 120; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1 out_rdy = $urandom_range(0, 2) != 0;
          end
          out_rdy = 1;
        end
      join
      drain();
      out_rdy = 0;
      repeat (s ? 1 : 2) send_rand();
      vld = 1; data = DW'($urandom) | 28'h1; expn = 10'd30; tag = 4'hf; flush = 1;
      @(negedge clk);
      if (sel) q1.delete(); else q0.delete();
      @(posedge clk);
      #1 flush = 0;
      vld = 0;
      @(negedge clk);
      chk(s ? "u1 flush out_vld" : "u2 flush out_vld", 64'(sel ? b1.out_vld : b0.out_vld), 64'(0));
      chk(s ? "u1 flush in_rdy" : "u2 flush in_rdy", 64'(rdy), 64'(1));
      @(posedge clk);
      #1 out_rdy = 1;
      repeat (5) @(posedge clk);
      #1;
      send_rand();
      drain();
    end
    out_rdy = 0;
    sel = 0;
    repeat (2) send_rand();
    sel = 1;
    send_rand();
    rst = 1;
    @(negedge clk);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 out_rdy = 1;
    sel = 0;
    repeat (4) send_rand();
    sel = 1;
    repeat (4) send_rand();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
